acf_axil_slave_regs: RTL and testbench
======================================

// Module: acf_axil_slave_regs
// PURPOSE
//  AXI4-Lite responder (slave) exposing NUM_REGS 32-bit read/write registers.
//  Terminates the master-side AXI4-Lite traffic issued by the Master VIP in the ACF_AXI block design.
//  One outstanding write and one outstanding read. The write and read channels run independently.
//  Register contents drive the reg_q output for user logic in the ACF_AXI IP.
// PARAMETERS
//  DATA_WIDTH   32  AXI data width; only 32 is supported
//  ADDR_WIDTH   4   AXI byte-address width; word index = addr[ADDR_WIDTH-1:2]
//  NUM_REGS     4   number of registers; must satisfy NUM_REGS <= 2**(ADDR_WIDTH-2)
// PORTS
//  ACLK        in   1                   single clock; all logic on its rising edge
//  ARESET      in   1                   synchronous, active-high reset
//  S_AXI_AWADDR   in   ADDR_WIDTH        write address
//  S_AXI_AWPROT   in   3                 ignored
//  S_AXI_AWVALID  in   1                 / S_AXI_AWREADY out 1
//  S_AXI_WDATA    in   32                write data
//  S_AXI_WSTRB    in   4                 byte enables; WSTRB[b] writes bits [8b+7:8b]
//  S_AXI_WVALID   in   1                 / S_AXI_WREADY  out 1
//  S_AXI_BRESP    out  2                 write response
//  S_AXI_BVALID   out  1                 / S_AXI_BREADY  in  1
//  S_AXI_ARADDR   in   ADDR_WIDTH        read address
//  S_AXI_ARPROT   in   3                 ignored
//  S_AXI_ARVALID  in   1                 / S_AXI_ARREADY out 1
//  S_AXI_RDATA    out  32                read data
//  S_AXI_RRESP    out  2                 read response
//  S_AXI_RVALID   out  1                 / S_AXI_RREADY  in  1
//  reg_q          out  32*NUM_REGS       register file contents; reg i is bits [32i+31:32i]
// BEHAVIOUR
//  Reset (ARESET=1 at an edge): all outputs 0, all registers 0, both FSMs go to IDLE.
//   - Applies mid-transaction: a pending B or R response is dropped and any latched AW/W is discarded.
//   - READY outputs rise on the first edge after ARESET deasserts.
//  Write FSM: W_IDLE -> W_COMMIT -> W_RESP -> W_IDLE.
//   - W_IDLE: AWREADY=1 until the AW beat is captured; WREADY=1 until the W beat is captured.
//     AW and W may arrive in the same cycle or in either order; each READY drops the cycle after its handshake.
//   - When both beats are held, go to W_COMMIT; AWREADY=WREADY=0 there.
//   - W_COMMIT lasts 1 cycle: the strobed bytes are written, BRESP is set, and BVALID=1 on the next edge.
//   - W_RESP: BVALID and BRESP stay stable until BREADY=1. The FSM then returns to W_IDLE and BVALID=0 on that edge.
//   - Minimum AW/W handshake-to-BVALID latency is 2 cycles.
//  Read FSM: R_IDLE -> R_RESP -> R_IDLE.
//   - R_IDLE: ARREADY=1. On ARVALID&ARREADY, RDATA/RRESP are registered and RVALID=1 on the same edge; ARREADY=0.
//   - R_RESP: RDATA, RRESP and RVALID stay stable until RREADY=1, then RVALID=0 and the FSM returns to R_IDLE.
//   - Handshake-to-RVALID latency is 1 cycle.
//  Address decode: idx = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored; in range iff idx < NUM_REGS.
//  Read during a same-address write commit on the same edge returns the pre-write value.
//  In-range accesses always respond OKAY (2'b00). Out-of-range handling is set by the macro below.
//  A write with WSTRB=0 leaves the register unchanged and still responds.
// CONFIGURATION
//  ACF_AXIL_RESP_ERR_EN defined:
//   - out-of-range write: no register change, BRESP=SLVERR (2'b10).
//   - out-of-range read: RDATA=0, RRESP=SLVERR.
//  ACF_AXIL_RESP_ERR_EN undefined:
//   - out-of-range write: silently dropped, BRESP=OKAY.
//   - out-of-range read: RDATA=0, RRESP=OKAY.
//  In-range behaviour is identical in both builds.
// TESTING
//  1. Write 0x1,0x2,0x3,0x4 to addrs 0x0,0x4,0x8,0xC with WSTRB=0xF, then read all four.
//     -> RDATA 0x1..0x4, all responses OKAY.
//  2. Write 0xAABBCCDD to 0x4 with WSTRB=0xF, then 0x11223344 with WSTRB=0x5. Read 0x4.
//     -> 0xAA22CC44.
//  3. W beat 3 cycles before AW, and a second write with AW before W; BREADY held low for 4 cycles.
//     -> one BVALID per write, held stable, no further AW/W accepted until B completes.
//  4. ARESET pulsed for 1 cycle while BVALID=1 and RVALID=1.
//     -> BVALID=RVALID=0 next edge, reg_q=0, READYs high the cycle after reset release.
//  5. Build with ACF_AXIL_RESP_ERR_EN and NUM_REGS=3; write 0x5 to 0xC, then read 0xC.
//     -> BRESP=2'b10, RRESP=2'b10, RDATA=0, reg_q unchanged.
//     Without the macro -> both responses 2'b00.
//  6. Read 0x8 on the same edge as a write-commit of 0x9 to 0x8 (prior value 0x3).
//     -> RDATA=0x3; a subsequent read returns 0x9.

Source files
------------

// File: rtl/acf_axil_slave_regs.sv
// AXI4-Lite slave exposing NUM_REGS read/write registers with independent write and read channels.
// Optional macro ACF_AXIL_RESP_ERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module acf_axil_slave_regs #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 4
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                     S_AXI_AWPROT,
    input  logic                           S_AXI_AWVALID,
    output logic                           S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                           S_AXI_WVALID,
    output logic                           S_AXI_WREADY,
    output logic [1:0]                     S_AXI_BRESP,
    output logic                           S_AXI_BVALID,
    input  logic                           S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                     S_AXI_ARPROT,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,
    output logic [DATA_WIDTH*NUM_REGS-1:0] reg_q
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int NB    = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef ACF_AXIL_RESP_ERR_EN
    localparam logic [1:0] RESP_OOR  = 2'b10;
`else
    localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_RESP}           r_state_e;

    // ---------------- write channel ----------------
    w_state_e              w_state_q, w_state_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NB-1:0]         wstrb_q, wstrb_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  commit;
    logic                  aw_in_range;

    assign aw_in_range = 32'(aw_idx_q) < NUM_REGS;

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        aw_idx_d  = aw_idx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        commit    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (S_AXI_AWVALID && awready_q) begin
                    aw_held_d = 1'b1;
                    aw_idx_d  = S_AXI_AWADDR[ADDR_WIDTH-1:2];
                end
                if (S_AXI_WVALID && wready_q) begin
                    w_held_d = 1'b1;
                    wdata_d  = S_AXI_WDATA;
                    wstrb_d  = S_AXI_WSTRB;
                end
                if (aw_held_d && w_held_d) begin
                    w_state_d = W_COMMIT;
                end
            end
            W_COMMIT: begin
                commit    = 1'b1;
                aw_held_d = 1'b0;
                w_held_d  = 1'b0;
                bvalid_d  = 1'b1;
                bresp_d   = aw_in_range ? RESP_OKAY : RESP_OOR;
                w_state_d = W_RESP;
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        // READYs are registered so they stay low through reset and rise one edge after release
        awready_d = (w_state_d == W_IDLE) && !aw_held_d;
        wready_d  = (w_state_d == W_IDLE) && !w_held_d;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            aw_idx_q  <= aw_idx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // ---------------- register file ----------------
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        logic [DATA_WIDTH-1:0] reg_word_q;

        always_ff @(posedge ACLK) begin
            if (ARESET) begin
                reg_word_q <= '0;
            end else if (commit && (aw_idx_q == IDX_W'(gi))) begin
                for (int b = 0; b < NB; b++) begin
                    if (wstrb_q[b]) begin
                        reg_word_q[8*b +: 8] <= wdata_q[8*b +: 8];
                    end
                end
            end
        end

        assign reg_q[DATA_WIDTH*gi +: DATA_WIDTH] = reg_word_q;
    end

    // ---------------- read channel ----------------
    r_state_e              r_state_q, r_state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [IDX_W-1:0]      ar_idx;
    logic                  ar_in_range;
    logic [DATA_WIDTH-1:0] rd_word;

    assign ar_idx      = S_AXI_ARADDR[ADDR_WIDTH-1:2];
    assign ar_in_range = 32'(ar_idx) < NUM_REGS;

    // Reads sample the registered contents, so a same-edge commit is not yet visible
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (32'(ar_idx) == i) begin
                rd_word = reg_q[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (S_AXI_ARVALID && arready_q) begin
                    rvalid_d  = 1'b1;
                    rdata_d   = ar_in_range ? rd_word : '0;
                    rresp_d   = ar_in_range ? RESP_OKAY : RESP_OOR;
                    r_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (S_AXI_RREADY) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_acf_axil_slave_regs.sv
// Randomized scoreboard bench for acf_axil_slave_regs: an array model predicts every B/R response,
// a negedge monitor pops and compares whenever a response handshake is presented.
module tb_acf_axil_slave_regs;

    localparam int AW  = 5;
    localparam int NR  = 4;
    localparam int TMO = 64;
`ifdef ACF_AXIL_RESP_ERR_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    logic            clk = 1'b0;
    logic            areset = 1'b1;
    logic [AW-1:0]   awaddr = '0;
    logic [2:0]      awprot = 3'b000;
    logic            awvalid = 1'b0;
    logic            awready;
    logic [31:0]     wdata = '0;
    logic [3:0]      wstrb = '0;
    logic            wvalid = 1'b0;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready = 1'b0;
    logic [AW-1:0]   araddr = '0;
    logic [2:0]      arprot = 3'b000;
    logic            arvalid = 1'b0;
    logic            arready;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready = 1'b0;
    logic [32*NR-1:0] reg_q;

    always #5 clk = ~clk;

    acf_axil_slave_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .NUM_REGS(NR)) u_dut (
        .ACLK(clk), .ARESET(areset),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .reg_q(reg_q)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { logic [1:0] resp; logic [32*NR-1:0] regs; } b_exp_t;
    typedef struct { logic [31:0] data; logic [1:0] resp; } r_exp_t;

    logic [31:0] model [NR];
    b_exp_t      b_q[$];
    r_exp_t      r_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [32*NR-1:0] snap();
        logic [32*NR-1:0] v;
        for (int i = 0; i < NR; i++) v[32*i +: 32] = model[i];
        return v;
    endfunction

    function automatic logic [1:0] model_write(input logic [AW-1:0] addr, input logic [31:0] data,
                                               input logic [3:0] strb);
        int idx;
        idx = int'(addr) / 4;
        if (idx >= NR) return OOR_RESP;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
        end
        return 2'b00;
    endfunction

    task automatic model_read(input logic [AW-1:0] addr, output logic [31:0] d, output logic [1:0] r);
        int idx;
        idx = int'(addr) / 4;
        if (idx < NR) begin
            d = model[idx];
            r = 2'b00;
        end else begin
            d = '0;
            r = OOR_RESP;
        end
    endtask

    // ---------------- stimulus helpers (all start just after a rising edge) ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_aw(input logic [AW-1:0] addr, input int dly);
        logic hs = 1'b0;
        int   k  = 0;
        cyc(dly);
        awaddr  = addr;
        awvalid = 1'b1;
        while (!hs && k < TMO) begin
            @(negedge clk); hs = awready;
            @(posedge clk); #1; k++;
        end
        awvalid = 1'b0;
        check("aw_handshake", hs, 1'b1);
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
        logic hs = 1'b0;
        int   k  = 0;
        cyc(dly);
        wdata  = data;
        wstrb  = strb;
        wvalid = 1'b1;
        while (!hs && k < TMO) begin
            @(negedge clk); hs = wready;
            @(posedge clk); #1; k++;
        end
        wvalid = 1'b0;
        check("w_handshake", hs, 1'b1);
    endtask

    task automatic send_ar(input logic [AW-1:0] addr, input int dly);
        logic hs = 1'b0;
        int   k  = 0;
        cyc(dly);
        araddr  = addr;
        arvalid = 1'b1;
        while (!hs && k < TMO) begin
            @(negedge clk); hs = arready;
            @(posedge clk); #1; k++;
        end
        arvalid = 1'b0;
        check("ar_handshake", hs, 1'b1);
    endtask

    task automatic take_b(input int dly);
        logic hs = 1'b0;
        int   k  = 0;
        cyc(dly);
        bready = 1'b1;
        while (!hs && k < TMO) begin
            @(negedge clk); hs = bvalid;
            @(posedge clk); #1; k++;
        end
        bready = 1'b0;
        check("b_handshake", hs, 1'b1);
    endtask

    task automatic take_r(input int dly);
        logic hs = 1'b0;
        int   k  = 0;
        cyc(dly);
        rready = 1'b1;
        while (!hs && k < TMO) begin
            @(negedge clk); hs = rvalid;
            @(posedge clk); #1; k++;
        end
        rready = 1'b0;
        check("r_handshake", hs, 1'b1);
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
        b_exp_t e;
        e.resp = model_write(addr, data, strb);
        e.regs = snap();
        b_q.push_back(e);
        fork
            send_aw(addr, aw_dly);
            send_w(data, strb, w_dly);
        join
        take_b(b_dly);
    endtask

    task automatic do_read_exp(input logic [AW-1:0] addr, input logic [31:0] d, input logic [1:0] r,
                               input int ar_dly, input int r_dly);
        r_exp_t e;
        e.data = d;
        e.resp = r;
        r_q.push_back(e);
        send_ar(addr, ar_dly);
        take_r(r_dly);
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int ar_dly, input int r_dly);
        logic [31:0] d;
        logic [1:0]  r;
        model_read(addr, d, r);
        do_read_exp(addr, d, r, ar_dly, r_dly);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic        b_wait = 1'b0;
    logic        r_wait = 1'b0;
    logic [1:0]  b_prev = '0;
    logic [1:0]  rr_prev = '0;
    logic [31:0] rd_prev = '0;

    always @(negedge clk) begin
        if (!areset) begin
            if (b_wait) check("b_stable", {bvalid, bresp}, {1'b1, b_prev});
            if (r_wait) check("r_stable", {rvalid, rresp, rdata}, {1'b1, rr_prev, rd_prev});
            if (bvalid) check("no_aw_w_during_b", {awready, wready}, 2'b00);
            if (rvalid) check("no_ar_during_r", arready, 1'b0);
            if (bvalid && bready) begin
                b_exp_t be;
                if (b_q.size() == 0) begin
                    check("b_unexpected", bvalid, 1'b0);
                end else begin
                    be = b_q.pop_front();
                    $display("[TB] write resp=%b reg_q=%h (exp resp=%b)", bresp, reg_q, be.resp);
                    check("bresp", bresp, be.resp);
                    check("reg_q_after_write", reg_q, be.regs);
                end
            end
            if (rvalid && rready) begin
                r_exp_t re;
                if (r_q.size() == 0) begin
                    check("r_unexpected", rvalid, 1'b0);
                end else begin
                    re = r_q.pop_front();
                    $display("[TB] read data=%h resp=%b (exp %h/%b)", rdata, rresp, re.data, re.resp);
                    check("rdata", rdata, re.data);
                    check("rresp", rresp, re.resp);
                end
            end
        end
        b_wait  = bvalid && !bready && !areset;
        r_wait  = rvalid && !rready && !areset;
        b_prev  = bresp;
        rr_prev = rresp;
        rd_prev = rdata;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] pre_d;
        logic [1:0]  pre_r;
        for (int i = 0; i < NR; i++) model[i] = '0;

        // reset state and READY release timing
        cyc(3);
        @(negedge clk);
        check("reset_outputs", {awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata},
              '0);
        check("reset_reg_q", reg_q, '0);
        @(posedge clk); #1; areset = 1'b0;
        @(negedge clk);
        check("ready_low_before_first_edge", {awready, wready, arready}, 3'b000);
        @(negedge clk);
        check("ready_high_after_release", {awready, wready, arready}, 3'b111);
        @(posedge clk); #1;

        // basic fill and readback
        for (int i = 0; i < 4; i++) do_write(AW'(4*i), 32'(i + 1), 4'hF, 0, 0, 0);
        for (int i = 0; i < 4; i++) do_read(AW'(4*i), 0, 0);

        // byte strobes
        do_write(AW'(4), 32'hAABBCCDD, 4'hF, 0, 0, 1);
        do_write(AW'(4), 32'h11223344, 4'h5, 1, 0, 0);
        do_read(AW'(4), 0, 2);
        do_write(AW'(6), 32'h5A5A5A5A, 4'h0, 0, 0, 0);
        do_read(AW'(5), 0, 0);

        // read on the same edge as a commit to the same register
        model_read(AW'(8), pre_d, pre_r);
        fork
            do_write(AW'(8), 32'h9, 4'hF, 0, 0, 0);
            do_read_exp(AW'(8), pre_d, pre_r, 1, 0);
        join
        do_read(AW'(8), 0, 0);

        // W before AW, AW before W, B held off
        do_write(AW'(12), 32'hCAFE0001, 4'hF, 3, 0, 6);
        do_write(AW'(0), 32'hCAFE0002, 4'hF, 0, 2, 6);

        // out-of-range boundary
        do_write(AW'(16), 32'h5, 4'hF, 0, 0, 0);
        do_read(AW'(16), 0, 0);
        do_read(AW'(31), 0, 1);

        // randomized traffic
        for (int t = 0; t < 60; t++) begin
            logic [AW-1:0] wa;
            logic [AW-1:0] ra;
            wa = AW'($urandom_range(0, 31));
            ra = AW'($urandom_range(0, 31));
            case ($urandom_range(0, 2))
                0: do_write(wa, $urandom, 4'($urandom_range(0, 15)),
                            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
                1: do_read(ra, $urandom_range(0, 3), $urandom_range(0, 3));
                default: begin
                    if (ra[AW-1:2] == wa[AW-1:2]) ra = ra ^ AW'(4);
                    fork
                        do_write(wa, $urandom, 4'($urandom_range(0, 15)),
                                 $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
                        do_read(ra, $urandom_range(0, 2), $urandom_range(0, 2));
                    join
                end
            endcase
        end

        // reset while both responses are pending
        awaddr = AW'(4); wdata = 32'hDEADBEEF; wstrb = 4'hF; araddr = AW'(0);
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        cyc(1);
        @(negedge clk);
        check("pre_reset_bvalid", bvalid, 1'b1);
        check("pre_reset_rvalid", rvalid, 1'b1);
        @(posedge clk); #1; areset = 1'b1;
        @(posedge clk); #1; areset = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        @(negedge clk);
        check("mid_reset_valids", {bvalid, rvalid}, 2'b00);
        check("mid_reset_reg_q", reg_q, snap());
        check("mid_reset_ready_low", {awready, wready, arready}, 3'b000);
        @(negedge clk);
        check("mid_reset_ready_high", {awready, wready, arready}, 3'b111);
        @(posedge clk); #1;

        do_write(AW'(8), 32'h12345678, 4'hF, 0, 1, 0);
        do_read(AW'(8), 0, 0);
        do_read(AW'(4), 0, 0);

        cyc(3);
        check("b_queue_drained", 32'(b_q.size()), 0);
        check("r_queue_drained", 32'(r_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
